// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the command, ALU-drive and result handshake signals around alu_cmd_sequencer.
// The slave modport is the sequencer's view; master is the surrounding system's view.
interface alu_cmd_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [3:0]       cmd_sel;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             alu_carry;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic [3:0]       res_sel;
    logic [15:0]      res_count;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, alu_carry, res_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_carry, res_sel,
               res_count
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, alu_carry, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_carry, res_sel,
               res_count
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Flow-controlled front-end for a combinational ALU: command FIFO, registered ALU drive,
// one-cycle result capture and a valid/ready result port.
module alu_cmd_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    alu_cmd_sequencer_if.slave bus
);
    localparam int unsigned   PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StDrive, StResult} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] mem_a   [DEPTH];
    logic [WIDTH-1:0] mem_b   [DEPTH];
    logic [3:0]       mem_sel [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;

    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_carry_q, res_carry_d;
    logic [3:0]       res_sel_q, res_sel_d;
    logic             res_valid_q, res_valid_d;
    logic [15:0]      res_count_q, res_count_d;

    logic full, empty, push, pop;

    assign full  = (count_q == FullCnt);
    assign empty = (count_q == '0);
    // No bypass: a full FIFO refuses even when a pop happens in the same cycle.
    assign bus.cmd_ready = !full && !reset;
    assign push  = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_sel_d   = res_sel_q;
        res_valid_d = res_valid_q;
        res_count_d = res_count_q;

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                res_data_d  = bus.alu_out;
                res_carry_d = bus.alu_carry;
                res_sel_d   = alu_sel_q;
                res_valid_d = 1'b1;
                state_d     = StResult;
            end
            StResult: begin
                if (bus.res_ready) begin
                    res_count_d = res_count_q + 16'd1;
                    res_valid_d = 1'b0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = StDrive;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (pop) begin
            alu_a_d   = mem_a[rd_ptr_q];
            alu_b_d   = mem_b[rd_ptr_q];
            alu_sel_d = mem_sel[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage needs no reset: an empty FIFO never reads it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_q]   <= bus.cmd_a;
            mem_b[wr_ptr_q]   <= bus.cmd_b;
            mem_sel[wr_ptr_q] <= bus.cmd_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_sel_q   <= '0;
            res_valid_q <= 1'b0;
            res_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_sel_q   <= res_sel_d;
            res_valid_q <= res_valid_d;
            res_count_q <= res_count_d;
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_carry = res_carry_q;
    assign bus.res_sel   = res_sel_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_count = res_count_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small stand-in ALU
// (add with carry, sub, and, or, xor; carry only meaningful for add).
module tb_alu_cmd_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_count = 0;
    int   lat;

    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.WIDTH(8)) bus ();

    alu_cmd_sequencer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always_comb begin
        bus.alu_out   = 8'h00;
        bus.alu_carry = 1'b0;
        case (bus.alu_sel)
            4'h0: {bus.alu_carry, bus.alu_out} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            4'h1: bus.alu_out = bus.alu_a - bus.alu_b;
            4'h8: bus.alu_out = bus.alu_a & bus.alu_b;
            4'h9: bus.alu_out = bus.alu_a | bus.alu_b;
            4'hA: bus.alu_out = bus.alu_a ^ bus.alu_b;
            default: bus.alu_out = 8'h00;
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] exp_data;
        logic       exp_carry;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; the command is offered for exactly one rising edge.
    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_sel   = s;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int cycles);
        cycles = 0;
        while (bus.res_valid !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check(name, {31'd0, bus.res_valid}, 32'd1);
    endtask

    task automatic expect_result(input string name, input logic [7:0] d, input logic c,
                                 input logic [3:0] s, output int cycles);
        wait_valid(name, cycles);
        check(name, {19'd0, bus.res_data, bus.res_carry, bus.res_sel}, {19'd0, d, c, s});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        vecs[0] = '{8'h0F, 8'h01, 4'h0, 8'h10, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 4'h0, 8'h00, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 4'h0, 8'h00, 1'b1};
        vecs[3] = '{8'h10, 8'h03, 4'h1, 8'h0D, 1'b0};
        vecs[4] = '{8'hF0, 8'h3C, 4'h8, 8'h30, 1'b0};
        vecs[5] = '{8'hF0, 8'h0F, 4'h9, 8'hFF, 1'b0};
        vecs[6] = '{8'hAA, 8'hFF, 4'hA, 8'h55, 1'b0};

        bus.cmd_valid = 1'b0;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        bus.cmd_sel   = 4'h0;
        bus.res_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check("rst_outputs", {bus.alu_a, bus.alu_b, bus.alu_sel, bus.res_valid, bus.res_carry,
                              bus.res_sel, 1'b0}, 32'd0);
        check("rst_res", {7'd0, bus.res_data, bus.res_count, 1'b0}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(negedge clk);

        // Table-driven single commands with res_ready high
        bus.res_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            push_cmd(vecs[i].a, vecs[i].b, vecs[i].sel);
            wait_valid("vec_valid", lat);
            check("vec_latency", lat, 32'd2);
            check("vec_result", {19'd0, bus.res_data, bus.res_carry, bus.res_sel},
                  {19'd0, vecs[i].exp_data, vecs[i].exp_carry, vecs[i].sel});
            @(negedge clk);
            exp_count++;
            check("vec_valid_drop", {31'd0, bus.res_valid}, 32'd0);
            check("vec_count", {16'd0, bus.res_count}, exp_count);
        end

        // Backpressure: one in the ALU, four in the FIFO, sixth refused
        bus.res_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_a     = 8'(16 * k + 1);
            bus.cmd_b     = 8'(k);
            bus.cmd_sel   = 4'h0;
            check("bp_cmd_ready", {31'd0, bus.cmd_ready}, (k < 5) ? 32'd1 : 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            expect_result("bp_result", 8'(17 * k + 1), 1'b0, 4'h0, lat);
            if (k > 0) check("bp_spacing", lat, 32'd1);
        end
        exp_count += 5;
        check("bp_count", {16'd0, bus.res_count}, exp_count);
        check("bp_idle", {31'd0, bus.res_valid}, 32'd0);

        // Push coinciding with a RESULT->DRIVE pop at occupancy 2
        bus.res_ready = 1'b0;
        push_cmd(8'h01, 8'h02, 4'h0);
        push_cmd(8'h03, 8'h04, 4'h0);
        push_cmd(8'h05, 8'h06, 4'h0);
        wait_valid("pp_first_valid", lat);
        check("pp_first", {24'd0, bus.res_data}, 32'h03);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 8'h07;
        bus.cmd_b     = 8'h08;
        bus.cmd_sel   = 4'h0;
        bus.res_ready = 1'b1;
        check("pp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        expect_result("pp_second", 8'h07, 1'b0, 4'h0, lat);
        expect_result("pp_third", 8'h0B, 1'b0, 4'h0, lat);
        expect_result("pp_fourth", 8'h0F, 1'b0, 4'h0, lat);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.res_valid === 1'b1) seen++;
            @(negedge clk);
        end
        check("pp_no_extra", seen, 32'd0);
        exp_count += 4;
        check("pp_count", {16'd0, bus.res_count}, exp_count);

        // Result stays frozen under backpressure while cmd inputs wiggle
        bus.res_ready = 1'b0;
        push_cmd(8'h12, 8'h34, 4'hA);
        wait_valid("hold_valid", lat);
        for (int k = 0; k < 10; k++) begin
            bus.cmd_a = 8'($urandom);
            @(negedge clk);
            check("hold_result", {18'd0, bus.res_valid, bus.res_data, bus.res_carry, bus.res_sel},
                  {18'd0, 1'b1, 8'h26, 1'b0, 4'hA});
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        exp_count++;
        check("hold_release", {15'd0, bus.res_valid, bus.res_count}, exp_count);

        // Asynchronous reset while in DRIVE with three commands queued
        bus.res_ready = 1'b0;
        for (int k = 0; k < 5; k++) push_cmd(8'(8'h40 + k), 8'h01, 4'h0);
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("pre_rst_drive", {23'd0, bus.res_valid, bus.alu_a}, 32'h41);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_zero", {bus.alu_a, bus.alu_b, bus.alu_sel, bus.res_data, bus.res_carry,
                                 bus.res_sel, bus.res_valid, bus.cmd_ready}, 32'd0);
        check("async_rst_count", {16'd0, bus.res_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst2_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(negedge clk);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.res_valid === 1'b1) seen++;
            @(negedge clk);
        end
        check("rst2_no_valid", seen, 32'd0);
        bus.res_ready = 1'b1;
        push_cmd(8'h20, 8'h22, 4'h0);
        expect_result("rst2_result", 8'h42, 1'b0, 4'h0, lat);
        check("rst2_latency", lat, 32'd2);
        check("rst2_count", {16'd0, bus.res_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
